// File: rtl/reorder_buffer.sv
// Reorder buffer indexed by RRF tag: records each dispatched destination, tracks completion
// and retires the head entry in program order, at most one per cycle.
module reorder_buffer #(
   parameter int unsigned RRF_NUM = 64,
   parameter int unsigned RRF_SEL = 6,
   parameter int unsigned REG_SEL = 5
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               dp_valid_i,
   input  logic [RRF_SEL-1:0] dp_rrftag_i,
   input  logic               dp_dst_en_i,
   input  logic [REG_SEL-1:0] dp_dst_num_i,
   input  logic               finish_we_i,
   input  logic [RRF_SEL-1:0] finish_rrftag_i,
   output logic [1:0]         com_inst_num_o,
   output logic               completed_we_o,
   output logic [REG_SEL-1:0] completed_dstnum_o,
   output logic [RRF_SEL-1:0] completed_rrftag_o,
   output logic [RRF_SEL-1:0] comptr_o,
   output logic [RRF_SEL:0]   rob_count_o,
   output logic               rob_empty_o,
   output logic               rob_full_o
);

   logic [RRF_NUM-1:0] r_valid;
   logic [RRF_NUM-1:0] r_finished;
   logic [RRF_NUM-1:0] r_dst_en;
   logic [REG_SEL-1:0] r_dst_num [RRF_NUM];
   logic [RRF_SEL-1:0] r_comptr;
   logic [RRF_SEL:0]   r_count;

   logic w_full;
   logic w_accept;
   logic w_commit;

   assign w_full   = (r_count == (RRF_SEL+1)'(RRF_NUM));
   assign w_accept = dp_valid_i & ~w_full;
   assign w_commit = r_valid[r_comptr] & r_finished[r_comptr];

   // Later assignments win: commit clears after a finish, dispatch overrides both.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_valid    <= '0;
         r_finished <= '0;
         r_comptr   <= '0;
         r_count    <= '0;
      end else begin
         if (finish_we_i && r_valid[finish_rrftag_i]) begin
            r_finished[finish_rrftag_i] <= 1'b1;
         end
         if (w_commit) begin
            r_valid[r_comptr]    <= 1'b0;
            r_finished[r_comptr] <= 1'b0;
            r_comptr             <= r_comptr + RRF_SEL'(1);
         end
         if (w_accept) begin
            r_valid[dp_rrftag_i]    <= 1'b1;
            r_finished[dp_rrftag_i] <= 1'b0;
         end
         r_count <= r_count + (RRF_SEL+1)'(w_accept) - (RRF_SEL+1)'(w_commit);
      end
   end

   // Payload needs no reset; it is only observed through a valid entry.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_dst_en[dp_rrftag_i]  <= dp_dst_en_i;
         r_dst_num[dp_rrftag_i] <= dp_dst_num_i;
      end
   end

   always_comb begin
      com_inst_num_o     = 2'd0;
      completed_we_o     = 1'b0;
      completed_dstnum_o = '0;
      if (w_commit) begin
         com_inst_num_o     = 2'd1;
         completed_we_o     = r_dst_en[r_comptr];
         completed_dstnum_o = r_dst_num[r_comptr];
      end
   end

   assign completed_rrftag_o = r_comptr;
   assign comptr_o           = r_comptr;
   assign rob_count_o        = r_count;
   assign rob_empty_o        = (r_count == '0);
   assign rob_full_o         = w_full;

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Reorder buffer (ROB) for the dispatch/rename stage, one entry per rename-register (RRF) slot and indexed by the allocated RRF tag. It records each dispatched instruction's architectural destination and tracks execution completion. It retires instructions strictly in program order, one per cycle. Its commit outputs drive the rename unit directly: the committed instruction count goes to the RRF allocator, and the destination number, RRF tag and write enable go to the ARF/RRF write-back path.

## Interface
Parameters:
- RRF_NUM, 64, number of ROB/RRF entries (power of two)
- RRF_SEL, 6, log2(RRF_NUM)
- REG_SEL, 5, architectural register index width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- dp_valid_i  in  1  dispatch one instruction this cycle; already gated by upstream stall
- dp_rrftag_i  in  RRF_SEL  allocated RRF tag, equal to allocator rrfptr; used as the entry index
- dp_dst_en_i  in  1  instruction writes an architectural register
- dp_dst_num_i  in  REG_SEL  architectural destination
- finish_we_i  in  1  execution unit reports completion
- finish_rrftag_i  in  RRF_SEL  tag of the completed instruction
- com_inst_num_o  out  2  instructions committed this cycle (0 or 1); feeds RrfEntryAllocate
- completed_we_o  out  1  ARF write enable for the committing entry
- completed_dstnum_o  out  REG_SEL  ARF destination of the committing entry
- completed_rrftag_o  out  RRF_SEL  RRF tag of the committing entry, equal to comptr_o
- comptr_o  out  RRF_SEL  head (oldest) entry pointer
- rob_count_o  out  RRF_SEL+1  occupied entries
- rob_empty_o  out  1  rob_count_o == 0
- rob_full_o  out  1  rob_count_o == RRF_NUM

## Operation
State:
- per-entry arrays: valid, finished, dst_en, dst_num
- comptr (RRF_SEL bits)
- count (RRF_SEL+1 bits)

Dispatch:
- Accepted when dp_valid_i is high and rob_full_o is low, using the pre-edge count.
- On accept, entry[dp_rrftag_i] gets valid=1, finished=0, and dst_en/dst_num from the inputs.
- Dispatch while full is dropped and state is unchanged. Upstream guarantees this never happens; the bench checks that the drop is clean.

Finish:
- On finish_we_i, set finished[finish_rrftag_i] only if that entry is valid.
- A finish to an invalid entry is ignored.

Commit (combinational decision from registered state):
- commit = valid[comptr] & finished[comptr].
- When commit is high:
  - com_inst_num_o = 1
  - completed_we_o = dst_en[comptr]
  - completed_dstnum_o = dst_num[comptr]
  - completed_rrftag_o = comptr
- On the clock edge after a commit, clear valid[comptr] and finished[comptr], and increment comptr modulo RRF_NUM (wrap 63 to 0).
- When commit is low: com_inst_num_o = 0, completed_we_o = 0, and completed_dstnum_o = 0.
- An entry with dst_en = 0 still commits and counts in com_inst_num_o, but does not write the ARF.

Count:
- count_next = count + accept - commit.
- Simultaneous dispatch and commit leaves count unchanged.

Simultaneous events:
- If a dispatch and a finish target the same tag in one cycle, the dispatch wins and finished stays 0.
- A finish of the head entry is visible to the commit logic in the next cycle.
- A dispatch into the slot being committed in the same cycle is impossible while not full (tail ≠ head). When full, the dispatch is dropped per the rule above.

## Timing
Reset, on the first rising edge with reset_i high:
- All valid and finished bits clear.
- comptr = 0, count = 0.
- Resulting outputs: com_inst_num_o = 0, completed_we_o = 0, completed_dstnum_o = 0, completed_rrftag_o = 0, comptr_o = 0, rob_count_o = 0, rob_empty_o = 1, rob_full_o = 0.
- Reset overrides any dispatch, finish or commit in the same cycle.
- Reset mid-operation discards all in-flight entries, and nothing commits in the reset cycle.

Latency:
- Dispatch edge T makes the entry valid from T+1.
- A finish sampled at edge T allows commit outputs during cycle T+1 at the earliest. An instruction can therefore commit two cycles after its dispatch edge if it finishes in the cycle right after dispatch.

Other timing rules:
- Commit outputs are combinational from registered state only, with no input-to-output paths.
- Throughput is one commit per cycle, and back-to-back commits are allowed.

## Test plan
- Reset and idle: assert reset_i for 2 cycles, then idle. All outputs must hold their reset values: rob_empty_o = 1, com_inst_num_o = 0.
- In-order retire: dispatch tags 0, 1, 2 with dst x5, x6, x7, then finish in order 2, 0, 1. Expected commits:
  - tag 0 (x5) one cycle after finish 0
  - tag 1 (x6) one cycle after finish 1
  - tag 2 (x7) in the cycle after tag 1
  - each commit has com_inst_num_o = 1 and completed_we_o = 1
- No-destination entry: dispatch tag 0 with dp_dst_en_i = 0, then finish it. Expect com_inst_num_o = 1, completed_we_o = 0, then comptr_o = 1.
- Full and wrap: fill all 64 entries, so rob_full_o = 1. A 65th dispatch is dropped and rob_count_o stays 64. Finish and retire all 64 entries; comptr_o wraps from 63 to 0 and rob_empty_o = 1.
- Simultaneous events:
  - dispatch tag 4 together with finish tag 4: entry 4 stays unfinished and does not commit
  - dispatch plus commit in one cycle: rob_count_o unchanged
  - finish to an unoccupied tag 9: no effect
- Reset mid-flight: with 10 entries, 3 of them finished, assert reset_i. The next cycle shows rob_count_o = 0 and comptr_o = 0. A stale finish of tag 2 after reset is ignored.
